riscv_wb_arbiter: RTL and testbench

Sequences the four writeback sources (exec, mem, csr, muldiv) onto the single register-file write port of riscv_decode. Each source owns a one-entry holding buffer with a valid/ready handshake. A round-robin or fixed-priority arbiter drains the buffers at one write per cycle. The block also preserves per-register write order and provides a hazard query so decode can stall on pending writes.

---
 rtl/riscv_wb_arbiter_if.sv | 59 +++++
 rtl/riscv_wb_arbiter.sv | 130 +++++++++++++
 tb/tb_riscv_wb_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_wb_arbiter_if.sv
// rtl/riscv_wb_arbiter_if.sv - writeback source, register-file write and hazard query signals
interface riscv_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            exec_valid_i;
  logic            exec_squash_i;
  logic [4:0]      exec_idx_i;
  logic [XLEN-1:0] exec_value_i;
  logic            exec_ready_o;

  logic            mem_valid_i;
  logic            mem_squash_i;
  logic [4:0]      mem_idx_i;
  logic [XLEN-1:0] mem_value_i;
  logic            mem_ready_o;

  logic            csr_valid_i;
  logic            csr_squash_i;
  logic [4:0]      csr_idx_i;
  logic [XLEN-1:0] csr_value_i;
  logic            csr_ready_o;

  logic            muldiv_valid_i;
  logic            muldiv_squash_i;
  logic [4:0]      muldiv_idx_i;
  logic [XLEN-1:0] muldiv_value_i;
  logic            muldiv_ready_o;

  logic            rf_wr_en_o;
  logic [4:0]      rf_wr_idx_o;
  logic [XLEN-1:0] rf_wr_value_o;
  logic [1:0]      rf_wr_src_o;

  logic [4:0]      hazard_idx_i;
  logic            hazard_o;
  logic            busy_o;

  modport master (
    output exec_valid_i, exec_squash_i, exec_idx_i, exec_value_i,
    output mem_valid_i, mem_squash_i, mem_idx_i, mem_value_i,
    output csr_valid_i, csr_squash_i, csr_idx_i, csr_value_i,
    output muldiv_valid_i, muldiv_squash_i, muldiv_idx_i, muldiv_value_i,
    output hazard_idx_i,
    input  exec_ready_o, mem_ready_o, csr_ready_o, muldiv_ready_o,
    input  rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, rf_wr_src_o,
    input  hazard_o, busy_o
  );

  modport slave (
    input  exec_valid_i, exec_squash_i, exec_idx_i, exec_value_i,
    input  mem_valid_i, mem_squash_i, mem_idx_i, mem_value_i,
    input  csr_valid_i, csr_squash_i, csr_idx_i, csr_value_i,
    input  muldiv_valid_i, muldiv_squash_i, muldiv_idx_i, muldiv_value_i,
    input  hazard_idx_i,
    output exec_ready_o, mem_ready_o, csr_ready_o, muldiv_ready_o,
    output rf_wr_en_o, rf_wr_idx_o, rf_wr_value_o, rf_wr_src_o,
    output hazard_o, busy_o
  );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// rtl/riscv_wb_arbiter.sv - sequences exec/mem/csr/muldiv writebacks onto one register-file write port
module riscv_wb_arbiter #(
  parameter bit RR_ENABLE = 1'b1,
  parameter int XLEN      = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  riscv_wb_arbiter_if.slave wb
);
  localparam int NSRC = 4;

  logic [NSRC-1:0] req_valid;
  logic [NSRC-1:0] req_squash;
  logic [NSRC-1:0] req_ready;
  logic [NSRC-1:0] blocked;
  logic [4:0]      req_idx   [NSRC];
  logic [XLEN-1:0] req_value [NSRC];

  logic [NSRC-1:0] buf_full;
  logic [4:0]      buf_idx   [NSRC];
  logic [XLEN-1:0] buf_value [NSRC];

  logic [1:0]      last_grant;
  logic            grant_valid;
  logic [1:0]      grant_src;
  logic [1:0]      cand;

  logic            rf_wr_en;
  logic [4:0]      rf_wr_idx;
  logic [XLEN-1:0] rf_wr_value;
  logic [1:0]      rf_wr_src;
  logic            hazard;

  // Source index order doubles as fixed priority: exec, mem, csr, muldiv.
  always_comb begin
    req_valid    = {wb.muldiv_valid_i, wb.csr_valid_i, wb.mem_valid_i, wb.exec_valid_i};
    req_squash   = {wb.muldiv_squash_i, wb.csr_squash_i, wb.mem_squash_i, wb.exec_squash_i};
    req_idx[0]   = wb.exec_idx_i;
    req_idx[1]   = wb.mem_idx_i;
    req_idx[2]   = wb.csr_idx_i;
    req_idx[3]   = wb.muldiv_idx_i;
    req_value[0] = wb.exec_value_i;
    req_value[1] = wb.mem_value_i;
    req_value[2] = wb.csr_value_i;
    req_value[3] = wb.muldiv_value_i;
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_src   = 2'd0;
    cand        = 2'd0;
    for (int k = 0; k < NSRC; k++) begin
      cand = RR_ENABLE ? last_grant + 2'(k + 1) : 2'(k);
      if (!grant_valid && buf_full[cand]) begin
        grant_valid = 1'b1;
        grant_src   = cand;
      end
    end
  end

  // One pending write per register: block on any occupied buffer or higher-priority request with the same idx.
  always_comb begin
    blocked   = '0;
    req_ready = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int t = 0; t < NSRC; t++) begin
        if (t != s && req_idx[s] != 5'd0) begin
          if (buf_full[t] && buf_idx[t] == req_idx[s]) blocked[s] = 1'b1;
          if (t < s && req_valid[t] && req_idx[t] == req_idx[s]) blocked[s] = 1'b1;
        end
      end
      req_ready[s] = !rst_i && !blocked[s]
                   && (!buf_full[s] || (grant_valid && grant_src == 2'(s)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_full    <= '0;
      last_grant  <= 2'd3;
      rf_wr_en    <= 1'b0;
      rf_wr_idx   <= 5'd0;
      rf_wr_value <= '0;
      rf_wr_src   <= 2'd0;
      for (int s = 0; s < NSRC; s++) begin
        buf_idx[s]   <= 5'd0;
        buf_value[s] <= '0;
      end
    end else begin
      rf_wr_en <= grant_valid;
      if (grant_valid) begin
        rf_wr_idx   <= buf_idx[grant_src];
        rf_wr_value <= buf_value[grant_src];
        rf_wr_src   <= grant_src;
        last_grant  <= grant_src;
      end
      // A refill on the grant edge wins over the free, giving one write per cycle per source.
      for (int s = 0; s < NSRC; s++) begin
        if (req_valid[s] && req_ready[s] && !req_squash[s] && req_idx[s] != 5'd0) begin
          buf_full[s]  <= 1'b1;
          buf_idx[s]   <= req_idx[s];
          buf_value[s] <= req_value[s];
        end else if (grant_valid && grant_src == 2'(s)) begin
          buf_full[s] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    if (wb.hazard_idx_i != 5'd0) begin
      if (rf_wr_en && rf_wr_idx == wb.hazard_idx_i) hazard = 1'b1;
      for (int s = 0; s < NSRC; s++) begin
        if (buf_full[s] && buf_idx[s] == wb.hazard_idx_i) hazard = 1'b1;
      end
    end
  end

  assign wb.exec_ready_o   = req_ready[0];
  assign wb.mem_ready_o    = req_ready[1];
  assign wb.csr_ready_o    = req_ready[2];
  assign wb.muldiv_ready_o = req_ready[3];
  assign wb.rf_wr_en_o     = rf_wr_en;
  assign wb.rf_wr_idx_o    = rf_wr_idx;
  assign wb.rf_wr_value_o  = rf_wr_value;
  assign wb.rf_wr_src_o    = rf_wr_src;
  assign wb.hazard_o       = hazard;
  assign wb.busy_o         = |buf_full;
endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// tb/tb_riscv_wb_arbiter.sv - round-robin and fixed-priority instances against a bench model
module tb_riscv_wb_arbiter;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]      in_v;
  logic [3:0]      in_sq;
  logic [4:0]      in_ix  [4];
  logic [XLEN-1:0] in_val [4];
  logic [4:0]      hidx;

  riscv_wb_arbiter_if #(.XLEN(XLEN)) bus_rr ();
  riscv_wb_arbiter_if #(.XLEN(XLEN)) bus_fp ();

  riscv_wb_arbiter #(.RR_ENABLE(1'b1), .XLEN(XLEN)) dut_rr (.clk_i(clk), .rst_i(rst), .wb(bus_rr));
  riscv_wb_arbiter #(.RR_ENABLE(1'b0), .XLEN(XLEN)) dut_fp (.clk_i(clk), .rst_i(rst), .wb(bus_fp));

  assign bus_rr.exec_valid_i    = in_v[0];  assign bus_fp.exec_valid_i    = in_v[0];
  assign bus_rr.exec_squash_i   = in_sq[0]; assign bus_fp.exec_squash_i   = in_sq[0];
  assign bus_rr.exec_idx_i      = in_ix[0]; assign bus_fp.exec_idx_i      = in_ix[0];
  assign bus_rr.exec_value_i    = in_val[0]; assign bus_fp.exec_value_i   = in_val[0];
  assign bus_rr.mem_valid_i     = in_v[1];  assign bus_fp.mem_valid_i     = in_v[1];
  assign bus_rr.mem_squash_i    = in_sq[1]; assign bus_fp.mem_squash_i    = in_sq[1];
  assign bus_rr.mem_idx_i       = in_ix[1]; assign bus_fp.mem_idx_i       = in_ix[1];
  assign bus_rr.mem_value_i     = in_val[1]; assign bus_fp.mem_value_i    = in_val[1];
  assign bus_rr.csr_valid_i     = in_v[2];  assign bus_fp.csr_valid_i     = in_v[2];
  assign bus_rr.csr_squash_i    = in_sq[2]; assign bus_fp.csr_squash_i    = in_sq[2];
  assign bus_rr.csr_idx_i       = in_ix[2]; assign bus_fp.csr_idx_i       = in_ix[2];
  assign bus_rr.csr_value_i     = in_val[2]; assign bus_fp.csr_value_i    = in_val[2];
  assign bus_rr.muldiv_valid_i  = in_v[3];  assign bus_fp.muldiv_valid_i  = in_v[3];
  assign bus_rr.muldiv_squash_i = in_sq[3]; assign bus_fp.muldiv_squash_i = in_sq[3];
  assign bus_rr.muldiv_idx_i    = in_ix[3]; assign bus_fp.muldiv_idx_i    = in_ix[3];
  assign bus_rr.muldiv_value_i  = in_val[3]; assign bus_fp.muldiv_value_i = in_val[3];
  assign bus_rr.hazard_idx_i    = hidx;     assign bus_fp.hazard_idx_i    = hidx;

  logic [3:0]      rdy  [2];
  logic            en   [2];
  logic [4:0]      oidx [2];
  logic [XLEN-1:0] oval [2];
  logic [1:0]      osrc [2];
  logic            haz  [2];
  logic            bsy  [2];

  assign rdy[0]  = {bus_rr.muldiv_ready_o, bus_rr.csr_ready_o, bus_rr.mem_ready_o, bus_rr.exec_ready_o};
  assign rdy[1]  = {bus_fp.muldiv_ready_o, bus_fp.csr_ready_o, bus_fp.mem_ready_o, bus_fp.exec_ready_o};
  assign en[0]   = bus_rr.rf_wr_en_o;    assign en[1]   = bus_fp.rf_wr_en_o;
  assign oidx[0] = bus_rr.rf_wr_idx_o;   assign oidx[1] = bus_fp.rf_wr_idx_o;
  assign oval[0] = bus_rr.rf_wr_value_o; assign oval[1] = bus_fp.rf_wr_value_o;
  assign osrc[0] = bus_rr.rf_wr_src_o;   assign osrc[1] = bus_fp.rf_wr_src_o;
  assign haz[0]  = bus_rr.hazard_o;      assign haz[1]  = bus_fp.hazard_o;
  assign bsy[0]  = bus_rr.busy_o;        assign bsy[1]  = bus_fp.busy_o;

  // Model, index 0 = round-robin instance, 1 = fixed-priority instance.
  bit              m_occ  [2][4];
  logic [4:0]      m_idx  [2][4];
  logic [XLEN-1:0] m_val  [2][4];
  int              m_last [2];
  bit              m_en   [2];
  logic [4:0]      m_oidx [2];
  logic [XLEN-1:0] m_oval [2];
  logic [1:0]      m_osrc [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int pick(input int d);
    for (int k = 1; k <= 4; k++) begin
      int s;
      s = (d == 0) ? (m_last[d] + k) % 4 : k - 1;
      if (m_occ[d][s]) return s;
    end
    return -1;
  endfunction

  function automatic bit exp_ready(input int d, input int s);
    if (rst) return 1'b0;
    if (m_occ[d][s] && pick(d) != s) return 1'b0;
    if (in_ix[s] != 5'd0) begin
      for (int t = 0; t < 4; t++) begin
        if (t != s && m_occ[d][t] && m_idx[d][t] == in_ix[s]) return 1'b0;
        if (t < s && in_v[t] && in_ix[t] == in_ix[s]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic bit exp_hazard(input int d);
    if (hidx == 5'd0) return 1'b0;
    if (m_en[d] && m_oidx[d] == hidx) return 1'b1;
    for (int s = 0; s < 4; s++) if (m_occ[d][s] && m_idx[d][s] == hidx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit r [4];
    int g;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int s = 0; s < 4; s++) m_occ[d][s] = 1'b0;
        m_en[d] = 1'b0; m_oidx[d] = '0; m_oval[d] = '0; m_osrc[d] = '0; m_last[d] = 3;
      end else begin
        g = pick(d);
        for (int s = 0; s < 4; s++) r[s] = exp_ready(d, s);
        m_en[d] = (g >= 0);
        if (g >= 0) begin
          m_oidx[d] = m_idx[d][g]; m_oval[d] = m_val[d][g]; m_osrc[d] = 2'(g);
          m_last[d] = g; m_occ[d][g] = 1'b0;
        end
        for (int s = 0; s < 4; s++) begin
          if (in_v[s] && r[s] && !in_sq[s] && in_ix[s] != 5'd0) begin
            m_occ[d][s] = 1'b1; m_idx[d][s] = in_ix[s]; m_val[d][s] = in_val[s];
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 4; s++)
        chk($sformatf("dut%0d ready[%0d]", d, s), 64'(rdy[d][s]), 64'(exp_ready(d, s)));
      chk($sformatf("dut%0d rf_wr_en", d), 64'(en[d]), 64'(m_en[d]));
      chk($sformatf("dut%0d rf_wr_idx", d), 64'(oidx[d]), 64'(m_oidx[d]));
      chk($sformatf("dut%0d rf_wr_value", d), 64'(oval[d]), 64'(m_oval[d]));
      chk($sformatf("dut%0d rf_wr_src", d), 64'(osrc[d]), 64'(m_osrc[d]));
      chk($sformatf("dut%0d hazard", d), 64'(haz[d]), 64'(exp_hazard(d)));
      bsy_chk(d);
    end
  endtask

  task automatic bsy_chk(input int d);
    bit b;
    b = 1'b0;
    for (int s = 0; s < 4; s++) b |= m_occ[d][s];
    chk($sformatf("dut%0d busy", d), 64'(bsy[d]), 64'(b));
  endtask

  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    in_v = '0; in_sq = '0;
    for (int s = 0; s < 4; s++) begin in_ix[s] = '0; in_val[s] = '0; end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic req(input int s, input logic [4:0] ix, input logic [XLEN-1:0] v, input bit sq);
    in_v[s] = 1'b1; in_ix[s] = ix; in_val[s] = v; in_sq[s] = sq;
  endtask

  int mdv_during_stream;

  initial begin
    clear_inputs();
    hidx = '0;
    rst  = 1'b1;
    @(posedge clk);
    model_step();
    @(negedge clk);

    // Reset held two cycles with exec requesting.
    req(0, 5'd3, 32'h33, 1'b0);
    #1;
    chk("reset exec_ready", 64'(rdy[0][0]), 64'd0);
    tick();
    chk("reset rf_wr_en", 64'(en[0]), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("no strobe one edge after reset", 64'(en[0]), 64'd0);
    in_v = '0;
    tick();
    chk("first strobe after reset", 64'(en[0]), 64'd1);
    chk("first strobe idx", 64'(oidx[0]), 64'd3);
    tick();

    // Single write and its hazard window.
    hidx = 5'd5;
    req(0, 5'd5, 32'hDEADBEEF, 1'b0);
    tick();
    in_v = '0;
    #1;
    chk("single hazard in buffer", 64'(haz[0]), 64'd1);
    chk("single en before grant edge", 64'(en[0]), 64'd0);
    tick();
    chk("single en", 64'(en[0]), 64'd1);
    chk("single idx", 64'(oidx[0]), 64'd5);
    chk("single value", 64'(oval[0]), 64'hDEADBEEF);
    chk("single src", 64'(osrc[0]), 64'd0);
    chk("single hazard at output", 64'(haz[0]), 64'd1);
    tick();
    chk("single hazard cleared", 64'(haz[0]), 64'd0);
    chk("single en cleared", 64'(en[0]), 64'd0);
    hidx = '0;

    // All four at once, then rotation.
    do_reset();
    for (int s = 0; s < 4; s++) req(s, 5'(s + 1), 32'(32'hA0 + s), 1'b0);
    #1;
    chk("all4 exec ready", 64'(rdy[0][0]), 64'd1);
    chk("all4 muldiv ready", 64'(rdy[0][3]), 64'd1);
    tick();
    in_v = '0;
    tick();
    chk("all4 strobe1 src", 64'(osrc[0]), 64'd0);
    chk("all4 strobe1 idx", 64'(oidx[0]), 64'd1);
    req(1, 5'd6, 32'h66, 1'b0);
    #1;
    chk("mem refill ready on grant", 64'(rdy[0][1]), 64'd1);
    tick();
    in_v = '0;
    chk("all4 strobe2 src", 64'(osrc[0]), 64'd1);
    tick();
    chk("all4 strobe3 src", 64'(osrc[0]), 64'd2);
    chk("all4 strobe3 en", 64'(en[0]), 64'd1);
    tick();
    chk("all4 strobe4 src", 64'(osrc[0]), 64'd3);
    tick();
    chk("refilled mem src", 64'(osrc[0]), 64'd1);
    chk("refilled mem idx", 64'(oidx[0]), 64'd6);
    req(0, 5'd10, 32'h10, 1'b0);
    req(1, 5'd11, 32'h11, 1'b0);
    tick();
    in_v = '0;
    tick();
    chk("rotation exec before mem", 64'(osrc[0]), 64'd0);
    tick();
    chk("rotation mem after exec", 64'(osrc[0]), 64'd1);

    // Same-idx conflict between mem and muldiv.
    req(1, 5'd7, 32'h71, 1'b0);
    req(3, 5'd7, 32'h73, 1'b0);
    #1;
    chk("conflict mem ready", 64'(rdy[0][1]), 64'd1);
    chk("conflict muldiv ready", 64'(rdy[0][3]), 64'd0);
    tick();
    in_v[1] = 1'b0;
    #1;
    chk("conflict muldiv blocked by buffer", 64'(rdy[0][3]), 64'd0);
    tick();
    chk("conflict first write src", 64'(osrc[0]), 64'd1);
    chk("conflict first write value", 64'(oval[0]), 64'h71);
    #1;
    chk("conflict muldiv ready after grant", 64'(rdy[0][3]), 64'd1);
    tick();
    in_v = '0;
    tick();
    chk("conflict second write src", 64'(osrc[0]), 64'd3);
    chk("conflict second write idx", 64'(oidx[0]), 64'd7);
    chk("conflict second write value", 64'(oval[0]), 64'h73);

    // Discarded requests.
    req(2, 5'd9, 32'h99, 1'b1);
    req(0, 5'd0, 32'h1234, 1'b0);
    #1;
    chk("discard csr ready", 64'(rdy[0][2]), 64'd1);
    chk("discard exec ready", 64'(rdy[0][0]), 64'd1);
    tick();
    clear_inputs();
    chk("discard busy", 64'(bsy[0]), 64'd0);
    chk("discard no strobe", 64'(en[0]), 64'd0);
    tick();
    chk("discard no later strobe", 64'(en[0]), 64'd0);

    // Fixed priority: muldiv waits while exec streams.
    do_reset();
    mdv_during_stream = 0;
    for (int i = 0; i < 8; i++) begin
      req(0, 5'(12 + i), 32'(32'hE0 + i), 1'b0);
      if (i == 0) req(3, 5'd20, 32'hD0, 1'b0);
      else in_v[3] = 1'b0;
      tick();
      if (en[1] && osrc[1] == 2'd3) mdv_during_stream++;
    end
    clear_inputs();
    chk("fp muldiv starved while exec streams", 64'(mdv_during_stream), 64'd0);
    tick();
    chk("fp last exec write src", 64'(osrc[1]), 64'd0);
    chk("fp last exec write idx", 64'(oidx[1]), 64'd19);
    tick();
    chk("fp muldiv once exec empty src", 64'(osrc[1]), 64'd3);
    chk("fp muldiv once exec empty idx", 64'(oidx[1]), 64'd20);
    tick();

    // Randomized traffic, small idx range to provoke conflicts.
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 127) == 0);
      for (int s = 0; s < 4; s++) begin
        in_v[s]   = $urandom_range(0, 1);
        in_sq[s]  = ($urandom_range(0, 7) == 0);
        in_ix[s]  = 5'($urandom_range(0, 7));
        in_val[s] = $urandom;
      end
      hidx = 5'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    for (int n = 0; n < 6; n++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
